// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the K=3 rate-1/2 Viterbi datapath: metric init, per-symbol
// ACS stepping with survivor-memory row addressing, full-frame traceback, done strobe.
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       sym_ready,
  output logic       acs_init,
  output logic       acs_en,
  output logic [1:0] acs_sym,
  output logic [3:0] sm_wr_addr,
  output logic       tb_en,
  output logic [3:0] tb_addr,
  output logic       dec_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SYM_W = 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_ACS  = 3'd2,
    S_TB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] sym_cnt_q;
  logic             accept_c;
  logic             last_sym_c;

  assign accept_c   = (state_q == S_ACS) && sym_valid;
  assign last_sym_c = (sym_cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; start outside IDLE is dropped, never queued
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: state_nxt = S_ACS;
      S_ACS:  if (accept_c && last_sym_c) state_nxt = S_TB;
      S_TB:   if (tb_addr == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Mealy datapath strobes, same cycle as the symbol handshake
  always_comb begin
    sym_ready  = 1'b0;
    acs_en     = 1'b0;
    acs_sym    = '0;
    sm_wr_addr = '0;
    if (state_q == S_ACS) begin
      sym_ready  = 1'b1;
      sm_wr_addr = sym_cnt_q;
      if (accept_c) begin
        acs_en  = 1'b1;
        acs_sym = SYM_W'(sym_in);
      end
    end
  end

  // Symbol counter: cleared in INIT, returns to 0 after the last symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      sym_cnt_q <= '0;
    end else if (accept_c) begin
      sym_cnt_q <= last_sym_c ? '0 : sym_cnt_q + CNT_W'(1);
    end
  end

  // Registered strobes, decoded from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acs_init  <= 1'b0;
      tb_en     <= 1'b0;
      tb_addr   <= '0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      acs_init  <= (state_nxt == S_INIT);
      tb_en     <= (state_nxt == S_TB);
      dec_valid <= tb_en;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      if (state_nxt == S_TB) begin
        tb_addr <= (state_q == S_TB) ? tb_addr - CNT_W'(1) : LAST_IDX;
      end else begin
        tb_addr <= '0;
      end
    end
  end

endmodule
